mat_vec_mult_param: RTL and testbench



---
 rtl/mat_vec_mult_param.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mat_vec_mult_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_mult_param.sv
// ============================================================================
// Module      : mat_vec_mult_param
// Description : Parametrised ROWS x COLS matrix-vector multiply engine.
//               One FIFO per matrix row (written in lockstep) plus one vector
//               FIFO feed a start/busy/done controlled multiply-accumulate
//               pass that produces ROWS dot products.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset (highest priority)
//   clr        in   synchronous clear of accumulators, out and FSM
//   a_wren     in   push a_fifo_in lane r into row FIFO r (all rows together)
//   a_fifo_in  in   ROWS*DATA_WIDTH row-lane data, lane r at [r*DATA_WIDTH +: DATA_WIDTH]
//   b_wren     in   push b_fifo_in into the vector FIFO
//   b_fifo_in  in   DATA_WIDTH vector element
//   start      in   request a pass (sampled in IDLE only)
//   a_full     out  row FIFO 0 full
//   b_full     out  vector FIFO full
//   a_empty    out  row FIFO 0 empty
//   b_empty    out  vector FIFO empty
//   busy       out  high in RUN and DRAIN
//   done       out  one-cycle pulse when out is updated
//   out        out  ROWS*ACC_WIDTH dot products, lane r at [r*ACC_WIDTH +: ACC_WIDTH]
// ----------------------------------------------------------------------------
// Build option:
//   MVM_SIGNED_EN  when defined, elements are two's complement and products
//                  are sign-extended before accumulation; otherwise unsigned.
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// mvm_fifo : synchronous FIFO with registered read data.
//   A push while full is dropped unless a pop happens in the same cycle, in
//   which case both take effect. A pop while empty is ignored.
// ----------------------------------------------------------------------------
module mvm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wren,
  input  logic [WIDTH-1:0]             din,
  input  logic                         rden,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign pop   = rden & ~empty;
  assign push  = wren & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (pop) begin
      dout <= mem[rptr];
    end
  end

endmodule

// ----------------------------------------------------------------------------
// mat_vec_mult_param : top level
// ----------------------------------------------------------------------------
module mat_vec_mult_param #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         a_wren,
  input  logic [ROWS*DATA_WIDTH-1:0]   a_fifo_in,
  input  logic                         b_wren,
  input  logic [DATA_WIDTH-1:0]        b_fifo_in,
  input  logic                         start,
  output logic                         a_full,
  output logic                         b_full,
  output logic                         a_empty,
  output logic                         b_empty,
  output logic                         busy,
  output logic                         done,
  output logic [ROWS*ACC_WIDTH-1:0]    out
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_NEED = CNT_W'(COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < COLS) begin : g_bad_depth
    $error("mat_vec_mult_param: FIFO_DEPTH (%0d) must be >= COLS (%0d)", FIFO_DEPTH, COLS);
  end
  if (ACC_WIDTH < PROD_W) begin : g_bad_acc
    $error("mat_vec_mult_param: ACC_WIDTH (%0d) must be >= 2*DATA_WIDTH (%0d)", ACC_WIDTH, PROD_W);
  end
  if (COLS < 1 || ROWS < 1) begin : g_bad_dims
    $error("mat_vec_mult_param: ROWS and COLS must be >= 1");
  end

  // --------------------------------------------------------------------------
  // FIFOs. All row FIFOs share write/read strobes, so one instance with a
  // ROWS-lane wide word holds the whole matrix column slice; its flags are
  // identical to those of row FIFO 0.
  // --------------------------------------------------------------------------
  logic                             pop;
  logic [ROWS-1:0][DATA_WIDTH-1:0]  rd_a;
  logic [DATA_WIDTH-1:0]            rd_b;
  logic [CNT_W-1:0]                 a_count;
  logic [CNT_W-1:0]                 b_count;

  mvm_fifo #(
    .WIDTH (ROWS * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_a_fifo (
    .clk   (clk),
    .rst   (rst),
    .wren  (a_wren),
    .din   (a_fifo_in),
    .rden  (pop),
    .dout  (rd_a),
    .full  (a_full),
    .empty (a_empty),
    .count (a_count)
  );

  mvm_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_b_fifo (
    .clk   (clk),
    .rst   (rst),
    .wren  (b_wren),
    .din   (b_fifo_in),
    .rden  (pop),
    .dout  (rd_b),
    .full  (b_full),
    .empty (b_empty),
    .count (b_count)
  );

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [COL_W-1:0] col_cnt;
  logic             drain_cnt;
  logic             ready;
  logic             pass_go;
  logic             capture;
  logic             mac_en;

  // A pass may only start when every FIFO already holds a full vector.
  assign ready = (a_count >= CNT_NEED) && (b_count >= CNT_NEED);

  // State register: clr aborts any pass back to IDLE.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && ready)       state_next = ST_RUN;
      ST_RUN:   if (col_cnt == COL_LAST)  state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt)            state_next = ST_DONE;
      ST_DONE:                            state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    pop     = 1'b0;
    pass_go = 1'b0;
    capture = 1'b0;
    case (state)
      ST_IDLE:  pass_go = start & ready;
      ST_RUN: begin
        busy = 1'b1;
        pop  = 1'b1;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        capture = drain_cnt;
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Column and drain counters. DRAIN spans two cycles: the first lets the
  // last read data land in the MAC, the second lets the last MAC settle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (pass_go) begin
        col_cnt <= '0;
      end else if (state == ST_RUN) begin
        col_cnt <= col_cnt + COL_W'(1);
      end
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Read data is registered, so the MAC consumes a pop one cycle later.
  // Clearing it on clr stops an in-flight product from reaching the
  // freshly zeroed accumulators.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mac_en <= 1'b0;
    end else begin
      mac_en <= pop;
    end
  end

  // --------------------------------------------------------------------------
  // MAC lanes: b is broadcast to every row lane.
  // --------------------------------------------------------------------------
  logic [ROWS*ACC_WIDTH-1:0] acc_all;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] prod_ext;

`ifdef MVM_SIGNED_EN
    logic signed [PROD_W-1:0] prod;
    // Size casts of signed operands sign-extend, giving a correct
    // two's-complement product in PROD_W bits.
    assign prod     = PROD_W'($signed(rd_a[r])) * PROD_W'($signed(rd_b));
    assign prod_ext = ACC_WIDTH'(prod);
`else
    logic [PROD_W-1:0] prod;
    assign prod     = PROD_W'(rd_a[r]) * PROD_W'(rd_b);
    assign prod_ext = ACC_WIDTH'(prod);
`endif

    // Accumulation wraps modulo 2^ACC_WIDTH by construction.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        acc <= '0;
      end else if (pass_go) begin
        acc <= '0;
      end else if (mac_en) begin
        acc <= acc + prod_ext;
      end
    end

    assign acc_all[r*ACC_WIDTH +: ACC_WIDTH] = acc;
  end

  // Result register, held until the next completed pass or a clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out <= '0;
    end else if (capture) begin
      out <= acc_all;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mat_vec_mult_param.sv
// ============================================================================
// Module      : tb_mat_vec_mult_param
// Description : Self-checking bench for mat_vec_mult_param (default 8x8).
//               A table of directed passes with hand-computed lane results,
//               followed by hand-written sequences for the start-ignored,
//               partial-load and clr-abort cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_vec_mult_param;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int ACC  = 24;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clr;
  logic                   a_wren;
  logic [ROWS*DW-1:0]     a_fifo_in;
  logic                   b_wren;
  logic [DW-1:0]          b_fifo_in;
  logic                   start;
  logic                   a_full;
  logic                   b_full;
  logic                   a_empty;
  logic                   b_empty;
  logic                   busy;
  logic                   done;
  logic [ROWS*ACC-1:0]    out;

  always #5 clk = ~clk;

  mat_vec_mult_param #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (8),
    .ACC_WIDTH  (ACC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .a_wren    (a_wren),
    .a_fifo_in (a_fifo_in),
    .b_wren    (b_wren),
    .b_fifo_in (b_fifo_in),
    .start     (start),
    .a_full    (a_full),
    .b_full    (b_full),
    .a_empty   (a_empty),
    .b_empty   (b_empty),
    .busy      (busy),
    .done      (done),
    .out       (out)
  );

  // Matrix element (r,j) = a_base + r*a_rstep + j*a_cstep, b_j = b_base + j*b_step.
  // Lane r result = exp0 + r*exp_step (unsigned and signed builds listed apart).
  typedef struct {
    logic [7:0]  a_base;
    logic [7:0]  a_rstep;
    logic [7:0]  a_cstep;
    logic [7:0]  b_base;
    logic [7:0]  b_step;
    logic [23:0] exp_u0;
    logic [23:0] exp_ustep;
    logic [23:0] exp_s0;
    logic [23:0] exp_sstep;
  } vec_t;

  localparam int NVEC = 5;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled on the next.
  task automatic push(input logic [ROWS*DW-1:0] a, input logic [DW-1:0] b,
                      input logic wa, input logic wb);
    a_fifo_in = a;
    b_fifo_in = b;
    a_wren    = wa;
    b_wren    = wb;
    @(posedge clk); #1;
    a_wren = 1'b0;
    b_wren = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [ROWS*DW-1:0] fill_a(input logic [7:0] val);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = val;
    return v;
  endfunction

  function automatic logic [ROWS*DW-1:0] a_col(input vec_t v, input int j);
    logic [ROWS*DW-1:0] res;
    logic [7:0]         e;
    for (int r = 0; r < ROWS; r++) begin
      e = v.a_base + 8'(r) * v.a_rstep + 8'(j) * v.a_cstep;
      res[r*DW +: DW] = e;
    end
    return res;
  endfunction

  // Start a pass and verify busy, start-to-done latency and the done pulse.
  task automatic run_pass(input string tag);
    int lat;
    pulse_start();
    check({tag, " busy after start"}, busy, 1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, " start-to-done edges"}, lat, COLS + 2);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy after done"}, busy, 0);
  endtask

  task automatic check_lanes(input string tag, input logic [23:0] e0, input logic [23:0] estep);
    logic [23:0] e;
    for (int r = 0; r < ROWS; r++) begin
      e = e0 + 24'(r) * estep;
      check($sformatf("%s lane%0d", tag, r), out[r*ACC +: ACC], e);
    end
  endtask

  initial begin
    logic [23:0] e0;
    logic [23:0] es;
    logic        saw_done;

    //                a_base a_rstep a_cstep b_base b_step  exp_u0   u_step  exp_s0     s_step
    vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 24'd8,      24'd0,  24'd8,      24'd0};
    vecs[1] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 24'd168,    24'd36, 24'd168,    24'd36};
    vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 24'h000FF0, 24'd0,  24'hFFFFF0, 24'd0};
    vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 24'd520200, 24'd0,  24'd8,      24'd0};
    vecs[4] = '{8'h80, 8'h00, 8'h00, 8'h80, 8'h00, 24'h020000, 24'd0,  24'h020000, 24'd0};

    rst       = 1'b1;
    clr       = 1'b0;
    start     = 1'b0;
    a_wren    = 1'b0;
    b_wren    = 1'b0;
    a_fifo_in = '0;
    b_fifo_in = '0;

    // ---- Reset state ------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    check("reset out", out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset a_empty", a_empty, 1);
    check("reset b_empty", b_empty, 1);
    check("reset a_full", a_full, 0);
    check("reset b_full", b_full, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    check("start on empty fifos ignored", busy, 0);

    // ---- Table-driven passes ----------------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      for (int j = 0; j < COLS; j++) begin
        push(a_col(vecs[i], j), vecs[i].b_base + 8'(j) * vecs[i].b_step, 1'b1, 1'b1);
      end
      check($sformatf("vec%0d a_full", i), a_full, 1);
      check($sformatf("vec%0d b_full", i), b_full, 1);
      // A ninth push into the full FIFOs must be dropped.
      push(fill_a(8'h55), 8'h55, 1'b1, 1'b1);
      run_pass($sformatf("vec%0d", i));
`ifdef MVM_SIGNED_EN
      e0 = vecs[i].exp_s0;
      es = vecs[i].exp_sstep;
`else
      e0 = vecs[i].exp_u0;
      es = vecs[i].exp_ustep;
`endif
      check_lanes($sformatf("vec%0d", i), e0, es);
      check($sformatf("vec%0d a_empty after", i), a_empty, 1);
      check($sformatf("vec%0d b_empty after", i), b_empty, 1);
    end

    // ---- Vector FIFO one short: start ignored, then a normal pass ---------
    for (int j = 0; j < COLS; j++) begin
      logic [ROWS*DW-1:0] av;
      for (int r = 0; r < ROWS; r++) av[r*DW +: DW] = 8'(r + 1);
      push(av, 8'd2, 1'b1, (j < COLS - 1));
    end
    pulse_start();
    check("short B start ignored", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("short B still idle", busy, 0);
    push('0, 8'd2, 1'b0, 1'b1);
    run_pass("shortB");
    check_lanes("shortB", 24'd16, 24'd16);

    // ---- clr on the third RUN cycle ---------------------------------------
    for (int j = 0; j < COLS; j++) push(fill_a(8'd3), 8'd3, 1'b1, 1'b1);
    pulse_start();                 // now in RUN cycle 1
    @(posedge clk); #1;            // RUN cycle 2
    @(posedge clk); #1;            // RUN cycle 3
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr busy", busy, 0);
    check("clr done", done, 0);
    check("clr out", out, 0);
    check("clr keeps fifo contents", a_empty, 0);
    pulse_start();
    check("start after abort ignored", busy, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no activity after abort", saw_done, 0);
    // Refill: excess pushes beyond full are dropped, all data is 3.
    for (int j = 0; j < COLS; j++) push(fill_a(8'd3), 8'd3, 1'b1, 1'b1);
    check("refill a_full", a_full, 1);
    check("refill b_full", b_full, 1);
    run_pass("refill");
    check_lanes("refill", 24'd72, 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
